load_store_unit: RTL and testbench

- Parametrised successor to the execute-stage memory helper. Adds byte/halfword loads and stores with sign/zero extension, byte-lane write strobes, and alignment/illegal-op faults.
- Accesses memory through a valid/ready handshake, so the core stalls on memory wait states instead of assuming a single-cycle bus.
- Sits between the execute stage (request side) and the data memory port (bus side).

---
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Valid/ready handshake with byte-lane write strobes.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses with extension, strobes and fault detection,
// talking to memory over a valid/ready bus. Define LSU_TIMEOUT_EN to add a bus wait timeout.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] wdata_in,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic [2:0]  rsp_cause,
    output logic        busy,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              store_q, store_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [2:0]        rsp_cause_q, rsp_cause_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    logic [31:0] addr;
    logic        accept, illegal, misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data, rd_shift, ld_data;

    assign addr   = base + offset;
    assign accept = req_valid && (req_load || req_store);

    always_comb begin
        illegal = (req_load && req_store)
               || (req_load  && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
               || (req_store && (funct3 >= 3'd3));
        misaligned = ((funct3[1:0] == 2'd1) && addr[0])
                  || ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'd0:    begin st_strb = 4'b0001 << addr[1:0]; st_data = {4{wdata_in[7:0]}};  end
            2'd1:    begin st_strb = 4'b0011 << addr[1:0]; st_data = {2{wdata_in[15:0]}}; end
            default: begin st_strb = 4'b1111;              st_data = wdata_in;            end
        endcase
    end

    // Shifting by the byte lane also aligns halfwords, since a legal halfword has lane[0]=0.
    assign rd_shift = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'd0:    ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'd1:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    ld_data = {24'b0, rd_shift[7:0]};
            3'd5:    ld_data = {16'b0, rd_shift[15:0]};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        rsp_cause_d = rsp_cause_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                lane_d   = addr[1:0];
                funct3_d = funct3;
                store_d  = req_store;
                if (illegal || misaligned) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_data_d  = 32'd0;
                    rsp_cause_d = illegal ? 3'd3 : (req_load ? 3'd1 : 3'd2);
                end else begin
                    state_d     = BUS;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = st_data;
                    mem_wstrb_d = req_store ? st_strb : 4'b0000;
`ifdef LSU_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end
            BUS: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_cause_d = 3'd0;
                    rsp_data_d  = store_q ? 32'd0 : ld_data;
                end
`ifdef LSU_TIMEOUT_EN
                // This is the TIMEOUT_CYCLES-th cycle without ready: give up.
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_cause_d = 3'd4;
                    rsp_data_d  = 32'd0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            funct3_q    <= 3'd0;
            store_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= 3'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_cause_q <= rsp_cause_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign busy          = !req_ready;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_fault     = rsp_fault_q;
    assign rsp_cause     = rsp_cause_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// hand sequences for wait states, reset mid-access and (with LSU_TIMEOUT_EN) bus timeout.
module tb_load_store_unit;
`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  funct3;
    logic [31:0] base, offset, wdata_in;
    logic        rsp_valid, rsp_fault, busy;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_cause;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .funct3(funct3),
        .base(base), .offset(offset), .wdata_in(wdata_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
        .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] base, off, wd, rd;
        logic        flt;
        logic [2:0]  cause;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] ewd, edata;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd);
        req_valid = 1'b1; req_load = ld; req_store = st;
        funct3 = f3; base = b; offset = o; wdata_in = wd;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    task automatic apply(input int i, input vec_t v);
        bus.mem_rdata = v.rd;
        drive(v.ld, v.st, v.f3, v.base, v.off, v.wd);
        chk($sformatf("v%0d_ready_pre", i), 32'(req_ready), 32'd1);
        tick();
        idle_req();
        if (v.flt) begin
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'd0);
            chk($sformatf("v%0d_fault", i), 32'(rsp_fault), 32'd1);
            chk($sformatf("v%0d_cause", i), 32'(rsp_cause), 32'(v.cause));
            chk($sformatf("v%0d_data", i), rsp_data, 32'd0);
        end else begin
            chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'd1);
            chk($sformatf("v%0d_addr", i), bus.mem_addr, v.addr);
            chk($sformatf("v%0d_wstrb", i), 32'(bus.mem_wstrb), 32'(v.strb));
            if (v.st) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, v.ewd);
            chk($sformatf("v%0d_rsp_early", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_data", i), rsp_data, v.edata);
            chk($sformatf("v%0d_fault", i), 32'(rsp_fault), 32'd0);
            chk($sformatf("v%0d_cause", i), 32'(rsp_cause), 32'd0);
            chk($sformatf("v%0d_mem_drop", i), 32'(bus.mem_valid), 32'd0);
        end
        tick();
        chk($sformatf("v%0d_rsp_one", i), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_ready_post", i), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //            ld  st  f3  base          off           wd            rd            flt cause addr          strb     ewd           edata
        vt[0]  = '{1, 0, 3'd2, 32'h100,      32'h4,        32'h0,        32'hDEADBEEF, 0, 3'd0, 32'h104,      4'b0000, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{1, 0, 3'd0, 32'h200,      32'h3,        32'h0,        32'h80FF1234, 0, 3'd0, 32'h200,      4'b0000, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1, 0, 3'd4, 32'h200,      32'h3,        32'h0,        32'h80FF1234, 0, 3'd0, 32'h200,      4'b0000, 32'h0,        32'h00000080};
        vt[3]  = '{1, 0, 3'd1, 32'h200,      32'h2,        32'h0,        32'h80FF1234, 0, 3'd0, 32'h200,      4'b0000, 32'h0,        32'hFFFF80FF};
        vt[4]  = '{1, 0, 3'd5, 32'h200,      32'h0,        32'h0,        32'h80FF1234, 0, 3'd0, 32'h200,      4'b0000, 32'h0,        32'h00001234};
        vt[5]  = '{0, 1, 3'd0, 32'h300,      32'h1,        32'hAB,       32'h0,        0, 3'd0, 32'h300,      4'b0010, 32'hABABABAB, 32'h0};
        vt[6]  = '{0, 1, 3'd1, 32'h300,      32'h2,        32'h1234CAFE, 32'h0,        0, 3'd0, 32'h300,      4'b1100, 32'hCAFECAFE, 32'h0};
        vt[7]  = '{0, 1, 3'd2, 32'h400,      32'hFFFFFFFC, 32'h11223344, 32'h0,        0, 3'd0, 32'h3FC,      4'b1111, 32'h11223344, 32'h0};
        vt[8]  = '{1, 0, 3'd2, 32'h100,      32'h2,        32'h0,        32'h0,        1, 3'd1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[9]  = '{0, 1, 3'd1, 32'h100,      32'h1,        32'h0,        32'h0,        1, 3'd2, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[10] = '{1, 0, 3'd3, 32'h100,      32'h0,        32'h0,        32'h0,        1, 3'd3, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[11] = '{1, 1, 3'd2, 32'h100,      32'h0,        32'h0,        32'h0,        1, 3'd3, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[12] = '{0, 1, 3'd4, 32'h100,      32'h0,        32'h0,        32'h0,        1, 3'd3, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[13] = '{1, 0, 3'd6, 32'h100,      32'h1,        32'h0,        32'h0,        1, 3'd3, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[14] = '{1, 0, 3'd0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h7F000000, 0, 3'd0, 32'hFFFFFFFC, 4'b0000, 32'h0,        32'h0000007F};

        rst = 1'b1; idle_req(); funct3 = 3'd0; base = 32'd0; offset = 32'd0; wdata_in = 32'd0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'd0;
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_cause", 32'(rsp_cause), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        rst = 1'b0;
        tick();

        // Valid without load/store must be ignored.
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0);
        tick();
        idle_req();
        chk("ign_req_ready", 32'(req_ready), 32'd1);
        chk("ign_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("ign_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();

        foreach (vt[i]) apply(i, vt[i]);

        // Five wait states: request held stable for six cycles.
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0BADF00D;
        drive(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ws%0d_mem_valid", i), 32'(bus.mem_valid), 32'd1);
            chk($sformatf("ws%0d_addr", i), bus.mem_addr, 32'h500);
            chk($sformatf("ws%0d_req_ready", i), 32'(req_ready), 32'd0);
            chk($sformatf("ws%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
            if (i == 5) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h12345678;
            end
            tick();
        end
        chk("ws_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_rsp_data", rsp_data, 32'h12345678);
        chk("ws_mem_drop", 32'(bus.mem_valid), 32'd0);
        tick();
        chk("ws_ready_post", 32'(req_ready), 32'd1);

        // Reset while the bus is waiting abandons the access.
        bus.mem_ready = 1'b0;
        drive(1'b0, 1'b1, 3'd2, 32'h600, 32'h0, 32'h55);
        tick();
        idle_req();
        chk("rb_mem_valid0", 32'(bus.mem_valid), 32'd1);
        tick();
        chk("rb_mem_valid1", 32'(bus.mem_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rb_req_ready", 32'(req_ready), 32'd1);
        chk("rb_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rb_wstrb", 32'(bus.mem_wstrb), 32'd0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        apply(100, vt[0]);

`ifdef LSU_TIMEOUT_EN
        begin
            bit seen;
            seen = 1'b0;
            bus.mem_ready = 1'b0;
            drive(1'b1, 1'b0, 3'd2, 32'h700, 32'h0, 32'h0);
            tick();
            idle_req();
            for (int i = 0; i < 40 && !seen; i++) begin
                if (rsp_valid) seen = 1'b1;
                else tick();
            end
            chk("tmo_seen", 32'(seen), 32'd1);
            chk("tmo_fault", 32'(rsp_fault), 32'd1);
            chk("tmo_cause", 32'(rsp_cause), 32'd4);
            chk("tmo_mem_valid", 32'(bus.mem_valid), 32'd0);
            bus.mem_ready = 1'b1;
            tick();
            apply(200, vt[0]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
